// File: rtl/usr_trx.sv
// Universal shift register: hold, shift right, shift left or parallel load,
// with the bit shifted out captured in a registered serial output.
module usr_trx #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] signal_input,
  input  logic [1:0]       select,
  output logic [WIDTH-1:0] signal_output,
  output logic             serial_output
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_SHR   = 2'b01,
    MODE_SHL   = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_t;

  if (WIDTH < 2) begin : g_width_check
    $error("usr_trx: WIDTH must be at least 2");
  end

  mode_t mode;
  assign mode = mode_t'(select);

  // Q and S are the output registers themselves, so there is no
  // combinational path from the inputs to the outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      signal_output <= '0;
      serial_output <= 1'b0;
    end else begin
      case (mode)
        MODE_HOLD: begin
          signal_output <= signal_output;
          serial_output <= serial_output;
        end
        MODE_SHR: begin
          signal_output <= {1'b0, signal_output[WIDTH-1:1]};
          serial_output <= signal_output[0];
        end
        MODE_SHL: begin
          signal_output <= {signal_output[WIDTH-2:0], 1'b0};
          serial_output <= signal_output[WIDTH-1];
        end
        MODE_LOAD: begin
          signal_output <= signal_input;
          serial_output <= serial_output;
        end
        default: begin
          signal_output <= signal_output;
          serial_output <= serial_output;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usr_trx.sv
// Directed bench for usr_trx: hand-computed vectors for every mode,
// drain behaviour and asynchronous reset.
module tb_usr_trx;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic [1:0] sel;
  logic [7:0] q;
  logic       s;

  int unsigned total;
  int unsigned bad;

  usr_trx #(.WIDTH(8)) dut (
    .CLK          (clk),
    .RST_N        (rst_n),
    .signal_input (din),
    .select       (sel),
    .signal_output(q),
    .serial_output(s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  // Apply sel/din at the falling edge, sample 1 ns after the rising edge.
  task automatic step(input logic [1:0] m, input logic [7:0] d);
    @(negedge clk);
    sel = m;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input logic [1:0] m, input logic [7:0] d,
                          input string tag, input logic [7:0] eq, input logic es);
    step(m, d);
    check({tag, "_q"}, q, eq);
    check({tag, "_s"}, {7'd0, s}, {7'd0, es});
  endtask

  initial begin
    logic [7:0] exp_q;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    sel   = 2'b00;
    din   = 8'h00;

    // Reset is visible before any clock edge has occurred
    #2;
    check("rst_q", q, 8'h00);
    check("rst_s", {7'd0, s}, 8'h00);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step_chk(2'b00, 8'hAA, "hold0", 8'h00, 1'b0);

    step_chk(2'b11, 8'h8C, "load", 8'h8C, 1'b0);
    step_chk(2'b01, 8'hFF, "shr1", 8'h46, 1'b0);
    step_chk(2'b01, 8'hFF, "shr2", 8'h23, 1'b0);
    step_chk(2'b01, 8'h00, "shr3", 8'h11, 1'b1);

    step_chk(2'b11, 8'h8C, "load2", 8'h8C, 1'b1);
    step_chk(2'b10, 8'h55, "shl1", 8'h18, 1'b1);
    step_chk(2'b10, 8'h55, "shl2", 8'h30, 1'b0);
    step_chk(2'b10, 8'h00, "shl3", 8'h60, 1'b0);
    step_chk(2'b10, 8'h00, "shl4", 8'hC0, 1'b0);
    step_chk(2'b10, 8'h00, "shl5", 8'h80, 1'b1);
    step_chk(2'b10, 8'h00, "shl6", 8'h00, 1'b1);

    // Mode sequence on the all-zero register
    step_chk(2'b01, 8'hFF, "zshr", 8'h00, 1'b0);
    step_chk(2'b10, 8'hFF, "zshl", 8'h00, 1'b0);
    step_chk(2'b11, 8'h8C, "zload", 8'h8C, 1'b0);
    step_chk(2'b00, 8'h8C, "zhold", 8'h8C, 1'b0);

    // Mid-cycle glitches on select/din must not matter
    @(negedge clk);
    sel = 2'b11;
    din = 8'hFF;
    #2;
    sel = 2'b01;
    #1;
    sel = 2'b00;
    din = 8'h3C;
    @(posedge clk);
    #1;
    check("glitch_q", q, 8'h8C);
    check("glitch_s", {7'd0, s}, 8'h00);

    // Async reset mid-operation
    step_chk(2'b11, 8'hFF, "ld_ff", 8'hFF, 1'b0);
    step_chk(2'b10, 8'h00, "shl_fe", 8'hFE, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_q", q, 8'h00);
    check("arst_s", {7'd0, s}, 8'h00);
    step(2'b11, 8'h77);
    check("arst_edge_q", q, 8'h00);

    // First edge after release performs the selected operation
    @(negedge clk);
    rst_n = 1'b1;
    step_chk(2'b11, 8'hFF, "post_rst_ld", 8'hFF, 1'b0);

    exp_q = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      exp_q = exp_q << 1;
      step_chk(2'b10, 8'hA5, $sformatf("drain%0d", i), exp_q, 1'b1);
    end
    check("drain_final", q, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/usr_trx.md
USR_TRX -- requirements
Module: usr_trx

Interface
REQ-001 Parameter WIDTH, default 8, register and parallel-port width; all values in this document assume WIDTH=8.
REQ-002 CLK  input  1  clock; all state updates on the rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 signal_input  input  WIDTH  parallel load data.
REQ-005 select  input  2  mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-006 signal_output  output  WIDTH  registered contents of the shift register.
REQ-007 serial_output  output  1  registered bit most recently shifted out of the register.

Function
REQ-008 The block SHALL hold one WIDTH-bit state register Q driven directly onto signal_output.
REQ-009 The block SHALL hold one 1-bit state register S driven directly onto serial_output.
REQ-010 select=00 (hold): Q and S SHALL keep their values at the clock edge.
REQ-011 select=01 (shift right): Q SHALL become {1'b0, Q[WIDTH-1:1]}, and S SHALL become the old Q[0].
REQ-012 select=10 (shift left): Q SHALL become {Q[WIDTH-2:0], 1'b0}, and S SHALL become the old Q[WIDTH-1].
REQ-013 select=11 (parallel load): Q SHALL become signal_input, and S SHALL hold its value.
REQ-014 Latency SHALL be one clock: outputs reflect the operation selected at the rising edge immediately after that edge; there is no combinational path from inputs to outputs.
REQ-015 Shift operations SHALL insert 0 at the vacated end; no wrap-around or rotation.
REQ-016 signal_input SHALL be ignored in every mode other than 11.
REQ-017 Changes on select or signal_input between clock edges SHALL have no effect on the outputs.
REQ-018 Consecutive shifts SHALL drain the register: after WIDTH shifts in one direction, Q=0.
REQ-019 Shifting an all-zero register SHALL leave Q=0 and set S=0.
REQ-020 WIDTH SHALL be at least 2.

Reset
REQ-021 While RST_N=0, Q SHALL be 0 and S SHALL be 0, immediately and regardless of CLK.
REQ-022 Reset asserted mid-operation SHALL discard the current contents; no clock edge is required.
REQ-023 On the first rising edge with RST_N=1, the block SHALL perform the operation selected by select.
REQ-024 If RST_N rises coincident with a CLK edge, that edge SHALL be treated as still in reset.

Verification
REQ-025 Hold: RST_N=0 -> signal_output=0x00 and serial_output=0 with no clock; release RST_N, select=00 for 3 edges -> signal_output stays 0x00.
REQ-026 Load: select=11, signal_input=0x8C, one edge -> signal_output=0x8C, serial_output unchanged (0).
REQ-027 Shift right: load 0x8C, then select=01, one edge -> 0x46, serial_output=0; second edge -> 0x23, serial_output=0; third edge -> 0x11, serial_output=1.
REQ-028 Shift left: load 0x8C, then select=10, one edge -> 0x18, serial_output=1; second edge -> 0x30, serial_output=0.
REQ-029 Mode sequence on all-zero register: select 01 then 10 then 11 (signal_input=0x8C) then 00, one edge each -> 0x00, 0x00, 0x8C, 0x8C.
REQ-030 Async reset: load 0xFF, shift left once (0xFE, serial_output=1), then assert RST_N between edges -> signal_output=0x00 and serial_output=0 immediately; eight left shifts from 0xFF -> 0x00.
